// File: rtl/noc_host_scheduler.sv
// Round-robin front-end for the mesh host port at tile (0,0).
// Allows a single packet in flight and returns its result, or a timeout error, to the granted requester.
module noc_host_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [64*NUM_REQ-1:0]  req_a,
    input  logic [64*NUM_REQ-1:0]  req_b,
    input  logic [16*NUM_REQ-1:0]  req_ctrl,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [63:0]            rsp_data,
    output logic                   rsp_error,
    output logic [63:0]            host_in_a,
    output logic [63:0]            host_in_b,
    output logic [15:0]            host_in_ctrl,
    output logic                   host_in_valid,
    input  logic [63:0]            host_out_a,
    input  logic                   host_out_valid,
    output logic                   busy,
    output logic [15:0]            timeout_cnt
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    typedef enum logic [1:0] {StIdle, StInject, StWait, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, gnt_q, gnt_idx, cand;
    logic             gnt_found;
    logic [63:0]      a_q, b_q, rsp_data_q;
    logic [15:0]      ctrl_q, wait_cnt_q, timeout_cnt_q;
    logic             rsp_error_q;
    logic             expire;

    assign expire = (wait_cnt_q == LAST_WAIT);

    // Search upward from the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (gnt_found) state_d = StInject;
            StInject: state_d = host_out_valid ? StResp : StWait;
            StWait:   if (host_out_valid || expire) state_d = StResp;
            StResp:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        req_ready     = '0;
        rsp_valid     = '0;
        host_in_valid = (state_q == StInject);
        busy          = (state_q != StIdle);
        if (state_q == StIdle && gnt_found && !rst) begin
            req_ready = ONE << gnt_idx;
        end
        if (state_q == StResp) begin
            rsp_valid = ONE << gnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q         <= '0;
            gnt_q         <= '0;
            a_q           <= '0;
            b_q           <= '0;
            ctrl_q        <= '0;
            wait_cnt_q    <= '0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        a_q    <= req_a[64*gnt_idx +: 64];
                        b_q    <= req_b[64*gnt_idx +: 64];
                        ctrl_q <= req_ctrl[16*gnt_idx +: 16];
                        gnt_q  <= gnt_idx;
                        ptr_q  <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
                    end
                end
                StInject: begin
                    wait_cnt_q <= '0;
                    if (host_out_valid) begin
                        rsp_data_q  <= host_out_a;
                        rsp_error_q <= 1'b0;
                    end
                end
                StWait: begin
                    // A result arriving on the expiry cycle takes precedence over the timeout.
                    if (host_out_valid) begin
                        rsp_data_q  <= host_out_a;
                        rsp_error_q <= 1'b0;
                    end else if (expire) begin
                        rsp_data_q  <= '0;
                        rsp_error_q <= 1'b1;
                        if (timeout_cnt_q != 16'hFFFF) begin
                            timeout_cnt_q <= timeout_cnt_q + 16'd1;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data     = rsp_data_q;
    assign rsp_error    = rsp_error_q;
    assign host_in_a    = a_q;
    assign host_in_b    = b_q;
    assign host_in_ctrl = ctrl_q;
    assign timeout_cnt  = timeout_cnt_q;

endmodule

// File: tb/tb_noc_host_scheduler.sv
// Randomized bench for noc_host_scheduler against a transaction-level model of grant order,
// latency, result/timeout outcome and timeout count.
module tb_noc_host_scheduler;

    localparam int unsigned N  = 4;
    localparam int unsigned TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [64*N-1:0]   req_a;
    logic [64*N-1:0]   req_b;
    logic [16*N-1:0]   req_ctrl;
    logic [N-1:0]      rsp_valid;
    logic [63:0]       rsp_data;
    logic              rsp_error;
    logic [63:0]       host_in_a;
    logic [63:0]       host_in_b;
    logic [15:0]       host_in_ctrl;
    logic              host_in_valid;
    logic [63:0]       host_out_a;
    logic              host_out_valid;
    logic              busy;
    logic [15:0]       timeout_cnt;

    noc_host_scheduler #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .req_ctrl       (req_ctrl),
        .rsp_valid      (rsp_valid),
        .rsp_data       (rsp_data),
        .rsp_error      (rsp_error),
        .host_in_a      (host_in_a),
        .host_in_b      (host_in_b),
        .host_in_ctrl   (host_in_ctrl),
        .host_in_valid  (host_in_valid),
        .host_out_a     (host_out_a),
        .host_out_valid (host_out_valid),
        .busy           (busy),
        .timeout_cnt    (timeout_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    int          ptr_m = 0;
    int          to_m = 0;
    logic [63:0] last_data = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model of the arbitration rule: first requester at or above the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(ptr_m + k) % N]) return (ptr_m + k) % N;
        end
        return -1;
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) begin
            req_a[64*i +: 64]    = {$urandom, $urandom};
            req_b[64*i +: 64]    = {$urandom, $urandom};
            req_ctrl[16*i +: 16] = 16'($urandom);
        end
    endtask

    task automatic idle_cycles(input int cnt);
        for (int k = 0; k < cnt; k++) begin
            @(negedge clk);
            req_valid      = '0;
            host_out_valid = 1'($urandom_range(0, 1));
            host_out_a     = {$urandom, $urandom};
            #1;
            check_eq("idle_rsp_valid", 64'(rsp_valid), 64'd0);
            check_eq("idle_busy", 64'(busy), 64'd0);
            check_eq("idle_timeout_cnt", 64'(timeout_cnt), 64'(to_m));
        end
    endtask

    // d in 0..TO: result returned d cycles after injection; d < 0 or d > TO: no result.
    task automatic do_txn(input logic [N-1:0] mask, input int d, input logic [63:0] res);
        int          g;
        int          r;
        bit          tmo;
        logic [63:0] ea, eb;
        logic [15:0] ec;
        @(negedge clk);
        req_valid      = mask;
        host_out_valid = 1'($urandom_range(0, 1));
        host_out_a     = {$urandom, $urandom};
        #1;
        g  = pick(mask);
        ea = req_a[64*g +: 64];
        eb = req_b[64*g +: 64];
        ec = req_ctrl[16*g +: 16];
        check_eq("grant_busy", 64'(busy), 64'd0);
        check_eq("req_ready", 64'(req_ready), 64'd1 << g);
        check_eq("rsp_data_hold", rsp_data, last_data);
        ptr_m = (g + 1) % N;
        tmo   = (d < 0) || (d > int'(TO));
        r     = tmo ? 2 + int'(TO) : 2 + d;
        for (int n = 1; n <= r; n++) begin
            @(negedge clk);
            req_valid = N'($urandom);
            randomize_ops();
            if (n == r) host_out_valid = 1'($urandom_range(0, 1));
            else        host_out_valid = !tmo && (n == 1 + d);
            host_out_a = host_out_valid && n != r ? res : {$urandom, $urandom};
            #1;
            check_eq("req_ready_busy", 64'(req_ready), 64'd0);
            check_eq("host_in_valid", 64'(host_in_valid), 64'(n == 1));
            if (n == 1 || n == r) begin
                check_eq("host_in_a", host_in_a, ea);
                check_eq("host_in_b", host_in_b, eb);
                check_eq("host_in_ctrl", 64'(host_in_ctrl), 64'(ec));
            end
            if (n < r) begin
                check_eq("rsp_early", 64'(rsp_valid), 64'd0);
            end else begin
                if (tmo) to_m++;
                last_data = tmo ? 64'd0 : res;
                check_eq("rsp_valid", 64'(rsp_valid), 64'd1 << g);
                check_eq("rsp_data", rsp_data, last_data);
                check_eq("rsp_error", 64'(rsp_error), 64'(tmo));
                check_eq("timeout_cnt", 64'(timeout_cnt), 64'(to_m));
            end
        end
    endtask

    task automatic reset_mid_wait();
        @(negedge clk);
        host_out_valid = 1'b0;
        req_valid      = 4'b0010;
        #1;
        check_eq("rst_pre_ready", 64'(req_ready), 64'b0010);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            req_valid = '0;
            rst       = (n == 4);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_rsp_data", rsp_data, 64'd0);
        check_eq("rst_rsp_error", 64'(rsp_error), 64'd0);
        check_eq("rst_host_in_a", host_in_a, 64'd0);
        check_eq("rst_host_in_b", host_in_b, 64'd0);
        check_eq("rst_host_in_ctrl", 64'(host_in_ctrl), 64'd0);
        check_eq("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
        ptr_m     = 0;
        to_m      = 0;
        last_data = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            host_out_valid = 1'b1;
            host_out_a     = {$urandom, $urandom};
            #1;
            check_eq("late_rsp_valid", 64'(rsp_valid), 64'd0);
            check_eq("late_busy", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        rst            = 1'b1;
        req_valid      = '0;
        req_a          = '0;
        req_b          = '0;
        req_ctrl       = '0;
        host_out_a     = '0;
        host_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_req_ready", 64'(req_ready), 64'd0);
        check_eq("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("reset_rsp_data", rsp_data, 64'd0);
        check_eq("reset_host_in_valid", 64'(host_in_valid), 64'd0);
        check_eq("reset_host_in_a", host_in_a, 64'd0);
        check_eq("reset_timeout_cnt", 64'(timeout_cnt), 64'd0);

        // Round-robin with all requesters busy and the result back during injection.
        for (int i = 0; i < 5; i++) begin
            randomize_ops();
            do_txn(4'hF, 0, {$urandom, $urandom});
        end

        randomize_ops();
        req_a[64*2 +: 64]    = 64'd5;
        req_b[64*2 +: 64]    = 64'd7;
        req_ctrl[16*2 +: 16] = 16'h0001;
        do_txn(4'b0100, 2, 64'd12);

        randomize_ops();
        do_txn(4'b1001, -1, 64'd0);
        randomize_ops();
        do_txn(4'b0110, 1, {$urandom, $urandom});
        randomize_ops();
        do_txn(4'b0011, int'(TO), 64'd9);

        for (int t = 0; t < 150; t++) begin
            idle_cycles($urandom_range(0, 2));
            randomize_ops();
            do_txn(N'($urandom_range(1, 15)), $urandom_range(0, TO + 2), {$urandom, $urandom});
        end

        idle_cycles(4);
        reset_mid_wait();
        for (int i = 0; i < 4; i++) begin
            randomize_ops();
            do_txn(4'hF, $urandom_range(0, TO + 1), {$urandom, $urandom});
        end
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
